// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC engine, one micro-rotation per clock, valid/ready in and out
module cordic_rotator #(
  parameter int DATA_WIDTH = 16,
  parameter int ITERATIONS = 12,
  parameter int ITER_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  input  logic signed [15:0]           z_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH+1:0] x_out,
  output logic signed [DATA_WIDTH+1:0] y_out,
  output logic signed [15:0]           z_out,
  output logic                         busy
);
  localparam int W = DATA_WIDTH + 2;
  localparam logic signed [15:0] ATAN [16] = '{
    16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297, 16'sd651, 16'sd326, 16'sd163, 16'sd81,
    16'sd41, 16'sd20, 16'sd10, 16'sd5, 16'sd3, 16'sd1, 16'sd1, 16'sd0
  };
  typedef enum logic [1:0] {IDLE, ROTATE, HOLD} state_t;
  state_t state;
  logic signed [W-1:0] x, y, x_nx, y_nx;
  logic signed [15:0] z, z_nx;
  logic [ITER_WIDTH-1:0] i;
  logic last;
  always_comb begin
    x_nx = z[15] ? x + (y >>> i) : x - (y >>> i);
    y_nx = z[15] ? y - (x >>> i) : y + (x >>> i);
    z_nx = z[15] ? z + ATAN[i] : z - ATAN[i];
    last = i == ITER_WIDTH'(ITERATIONS - 1);
  end
  assign in_ready = en && state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && en) begin
          state <= ROTATE;
          x <= W'(x_in);
          y <= W'(y_in);
          z <= z_in;
          i <= '0;
        end
        ROTATE: begin
          x <= x_nx;
          y <= y_nx;
          z <= z_nx;
          i <= i + 1'b1;
          if (last) begin
            state <= HOLD;
            out_valid <= 1'b1;
            x_out <= x_nx;
            y_out <= y_nx;
            z_out <= z_nx;
          end
        end
        HOLD: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: directed and randomized checks of cordic_rotator against a plain-arithmetic model
module tb_cordic_rotator;
  localparam int DW = 16;
  localparam int N = 12;
  logic clk = 1'b0;
  logic rst, en, in_valid, out_ready;
  logic in_ready, out_valid, busy;
  logic signed [DW-1:0] x_in, y_in;
  logic signed [15:0] z_in, z_out;
  logic signed [DW+1:0] x_out, y_out;
  int n_chk = 0;
  int n_fail = 0;
  int atan_tab [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};

  cordic_rotator #(.DATA_WIDTH(DW), .ITERATIONS(N), .ITER_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
    n_chk++;
    assert (obs - exp <= tol && exp - obs <= tol) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  function automatic void model(input int xi, input int yi, input int zi,
                                output int xo, output int yo, output int zo);
    int x = xi, y = yi, xn;
    int z = int'(16'(zi));
    for (int k = 0; k < N; k++) begin
      z = int'($signed(16'(z)));
      if (z >= 0) begin
        xn = x - (y >>> k);
        y = y + (x >>> k);
        z = z - atan_tab[k];
      end else begin
        xn = x + (y >>> k);
        y = y - (x >>> k);
        z = z + atan_tab[k];
      end
      x = xn;
    end
    xo = x;
    yo = y;
    zo = int'($signed(16'(z)));
  endfunction

  function automatic int sx(input logic signed [DW+1:0] v);
    return int'(v);
  endfunction

  // Accepts one operand, checks latency, leaves the result presented (out_valid high).
  task automatic start_op(input int xi, input int yi, input int zi, input bit drop_en, input string tag);
    int n, ex, ey, ez;
    x_in = DW'(xi);
    y_in = DW'(yi);
    z_in = 16'(zi);
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !in_ready; c++) step();
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, int'(busy), 1);
    n = 1;
    while (!out_valid && n < 40) begin
      if (drop_en && n == 5) begin
        en = 1'b0;
        chk({tag, "_in_ready_en_low"}, int'(in_ready), 0);
      end
      step();
      n++;
    end
    chk({tag, "_latency"}, n, N + 1);
    model(xi, yi, zi, ex, ey, ez);
    chk({tag, "_x"}, sx(x_out), ex);
    chk({tag, "_y"}, sx(y_out), ey);
    chk({tag, "_z"}, int'(z_out), ez);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, "_out_valid_clear"}, int'(out_valid), 0);
    chk({tag, "_busy_clear"}, int'(busy), 0);
  endtask

  initial begin
    int hx, hy, hz, xi, yi, zi;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; y_in = '0; z_in = '0;
    step(); step();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_x_out", sx(x_out), 0);
    chk("rst_y_out", sx(y_out), 0);
    chk("rst_z_out", int'(z_out), 0);
    en = 1'b1;
    #1;
    chk("rst_in_ready_en", int'(in_ready), 1);
    en = 1'b0;
    rst = 1'b0;
    x_in = 16'sd10000; y_in = '0; z_in = '0; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("gate_in_ready", int'(in_ready), 0);
      chk("gate_busy", int'(busy), 0);
    end
    en = 1'b1;
    start_op(10000, 0, 0, 1'b0, "zero");
    chk_near("zero_x_tol", sx(x_out), 16468, 8);
    chk_near("zero_y_tol", sx(y_out), 0, 8);
    chk_near("zero_z_tol", int'(z_out), 0, 8);
    consume("zero");
    start_op(10000, 0, 8192, 1'b0, "pi4");
    chk_near("pi4_x_tol", sx(x_out), 11644, 8);
    chk_near("pi4_y_tol", sx(y_out), 11644, 8);
    consume("pi4");
    start_op(10000, 0, -16384, 1'b0, "neg");
    chk_near("neg_x_tol", sx(x_out), 0, 8);
    chk_near("neg_y_tol", sx(y_out), -16468, 8);
    consume("neg");
    out_ready = 1'b0;
    start_op(-7000, 12000, 5000, 1'b1, "bp");
    hx = sx(x_out); hy = sx(y_out); hz = int'(z_out);
    for (int c = 0; c < 30; c++) begin
      step();
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_busy", int'(busy), 1);
      chk("bp_x_hold", sx(x_out), hx);
      chk("bp_y_hold", sx(y_out), hy);
      chk("bp_z_hold", int'(z_out), hz);
    end
    en = 1'b1;
    consume("bp");
    x_in = 16'sd10000; y_in = '0; z_in = 16'sd3000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_x", sx(x_out), 0);
    chk("mid_rst_y", sx(y_out), 0);
    chk("mid_rst_z", int'(z_out), 0);
    start_op(10000, 0, 0, 1'b0, "post_rst");
    chk_near("post_rst_x_tol", sx(x_out), 16468, 8);
    consume("post_rst");
    for (int t = 0; t < 40; t++) begin
      xi = int'($urandom_range(40000)) - 20000;
      yi = int'($urandom_range(40000)) - 20000;
      zi = int'($urandom_range(65535)) - 32768;
      start_op(xi, yi, zi, 1'b0, "rand");
      out_ready = 1'b0;
      for (int s = int'($urandom_range(3)); s > 0; s--) begin
        step();
        chk("rand_hold_valid", int'(out_valid), 1);
      end
      consume("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cordic_rotator.md
# cordic_rotator

Iterative CORDIC engine in rotation mode; one micro-rotation per clock. Sits directly downstream of the `delay` start-up block: that block's `done` drives `en`, so operands are accepted only after the power-on settle count expires. It takes (x, y, z) over a valid/ready handshake and returns the rotated vector and residual angle over a second valid/ready handshake. Outputs are not gain-compensated; magnitude is scaled by K ≈ 1.6468.

## Interface
- `DATA_WIDTH`, 16: signed width of `x_in` and `y_in`.
- `ITERATIONS`, 12: micro-rotations per operation; legal range 1..16.
- `ITER_WIDTH`, 4: iteration counter width; must satisfy 2^ITER_WIDTH ≥ ITERATIONS.
- `clk` input 1: sole clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: acceptance enable, driven by `delay.done`.
- `in_valid` input 1: operand valid.
- `in_ready` output 1: high exactly when `en`=1 and state is IDLE; this is combinational from `en` and state.
- `x_in`, `y_in` input DATA_WIDTH: signed two's-complement operands.
- `z_in` input 16: signed binary angle; 32768 = π.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts.
- `x_out`, `y_out` output DATA_WIDTH+2: signed rotated vector.
- `z_out` output 16: signed residual angle.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ROTATE, HOLD. Reset → IDLE.
- IDLE → ROTATE on `in_valid && in_ready`:
  - load x and y sign-extended to DATA_WIDTH+2 bits;
  - load z;
  - clear iteration counter i to 0.
- ROTATE performs one micro-rotation per cycle:
  - d = +1 if z ≥ 0, else −1;
  - x ← x − d·(y >>> i);
  - y ← y + d·(x >>> i), using the old x;
  - z ← z − d·ATAN[i].
- Shifts are arithmetic and truncating; there is no rounding.
- ROTATE → HOLD after the iteration with i = ITERATIONS−1. `out_valid` is set on the same edge.
- HOLD → IDLE on `out_valid && out_ready`. `out_valid` clears on the same edge.
- ATAN ROM, 16-bit entries for i = 0..15: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- Input domain:
  - Convergence is guaranteed only for |z_in| ≤ 16384 (±π/2). Larger angles are processed identically with no quadrant correction.
  - Overflow-free for sqrt(x_in² + y_in²) < 2^(DATA_WIDTH−1). The two guard bits absorb the K growth.
  - z arithmetic wraps modulo 2^16.
- `x_out`, `y_out` and `z_out` are registered copies of x, y and z. They update only on the edge entering HOLD and are stable throughout HOLD.
- `en` behaviour:
  - Only gates acceptance.
  - Deassertion during ROTATE or HOLD does not stall or abort the operation.
  - The new `en` value affects `in_ready` in the same cycle.
- `in_valid` asserted while not IDLE is ignored. It causes no state or register change.

## Timing
- Reset values:
  - `in_ready` = `en` (state IDLE);
  - `out_valid` = 0, `busy` = 0;
  - `x_out`, `y_out`, `z_out` = 0;
  - i = 0, internal x, y, z = 0.
- Accept edge T0 loads the operands. Iterations occur on edges T1..T_ITERATIONS.
- `out_valid` is high starting the cycle after edge T_ITERATIONS. Latency is ITERATIONS+1 edges from the accept edge, i.e. 13 with defaults.
- Back-to-back operation:
  - Result-accept edge returns the FSM to IDLE.
  - `in_ready` goes high in the following cycle, given `en`.
  - Minimum initiation interval is ITERATIONS+2 cycles when `out_ready` is held high.
- `out_ready` low in HOLD holds all outputs indefinitely, with no loss or change.
- `rst` asserted in any state returns all outputs to reset values on that edge. An in-flight result is discarded.
- Reset dominates all handshakes in the same cycle.

## Test plan
- Gating by `en`:
  - stimulus: `en`=0, `in_valid`=1 for 20 cycles;
  - required: `in_ready`=0, `busy`=0 throughout;
  - then raise `en`: accept occurs on that same cycle's edge.
- Zero angle:
  - stimulus: x=10000, y=0, z=0, `out_ready`=1;
  - required: `out_valid` 13 edges after accept;
  - required: x_out = 16468±8, y_out = 0±8, |z_out| ≤ 8.
- π/4 rotation:
  - stimulus: x=10000, y=0, z=8192;
  - required: x_out = 11644±8, y_out = 11644±8.
- Negative angle:
  - stimulus: x=10000, y=0, z=−16384;
  - required: x_out = 0±8, y_out = −16468±8.
- Backpressure and `en` drop:
  - stimulus: hold `out_ready`=0 for 30 cycles after `out_valid`; deassert `en` mid-ROTATE;
  - required: outputs constant, `busy`=1, result completes normally;
  - required: `out_valid` clears on the edge where `out_ready`=1.
- Reset mid-operation:
  - stimulus: pulse `rst` at iteration 5;
  - required: next cycle `busy`=0, `out_valid`=0, outputs 0;
  - required: a subsequent z=0 operation completes with correct results.
